// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   EX stage of the 5-stage pipeline. Computes single-cycle ALU results and
//   load/store effective addresses, and runs an iterative 32-step
//   shift-add multiplier / restoring divider for MULT and DIVU. While a
//   multi-cycle op occupies EX, ex_stall_c freezes decode. The EX_MEM_*
//   register is also the EX forwarding source seen by decode.
//
//   Optional build macro: EX_OVF_TRAP_EN
//     Adds the registered output ex_ovf, which pulses for one cycle when
//     ADD/SUB/ADDI overflows (signed); that instruction does not write back.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   mem_stall_c    MEM stalled: hold every EX_MEM_* output
//   ID_EX_nextPC   PC+4 of the instruction in EX
//   ID_EX_A/B      forwarded rs / rt operands
//   ID_EX_imm      immediate, bits [15:0] used
//   ID_EX_rd/rt    R-type / I-type destination
//   ID_EX_op       funct (R-type) or opcode (I-type)
//   EX_MEM_nextPC  pass-through PC+4
//   EX_MEM_valid   result writes a nonzero register
//   EX_MEM_dest    destination register
//   EX_MEM_result  ALU result, product, quotient or effective address
//   EX_MEM_B       store data
//   EX_MEM_op      op pass-through for MEM
//   ex_ovf         (EX_OVF_TRAP_EN only) overflow pulse
//   ex_stall_c     combinational stall request to decode
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_stall_c,
  input  logic [31:0]       ID_EX_nextPC,
  input  logic [DATA_W-1:0] ID_EX_A,
  input  logic [DATA_W-1:0] ID_EX_B,
  input  logic [31:0]       ID_EX_imm,
  input  logic [4:0]        ID_EX_rd,
  input  logic [4:0]        ID_EX_rt,
  input  logic [5:0]        ID_EX_op,
  output logic [31:0]       EX_MEM_nextPC,
  output logic              EX_MEM_valid,
  output logic [4:0]        EX_MEM_dest,
  output logic [DATA_W-1:0] EX_MEM_result,
  output logic [DATA_W-1:0] EX_MEM_B,
  output logic [5:0]        EX_MEM_op,
`ifdef EX_OVF_TRAP_EN
  output logic              ex_ovf,
`endif
  output logic              ex_stall_c
);

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_MULT = 6'h18;
  localparam logic [5:0] OP_DIVU = 6'h1B;

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  logic signed [DATA_W-1:0] a_s_p0;
  logic signed [DATA_W-1:0] b_s_p0;
  logic signed [DATA_W-1:0] imm_sext_p0;
  logic [DATA_W-1:0]        imm_zext_p0;
  logic [DATA_W-1:0]        alu_res_p0;
  logic                     is_rtype_p0;
  logic                     is_itype_p0;
  logic                     writes_p0;
  logic                     muldiv_p0;
  logic [4:0]               dest_p0;
  logic                     vld_p0;
  logic                     unused_imm_hi;

  logic                     is_div_p1;
  logic [DATA_W-1:0]        work_a_p1;
  logic [DATA_W-1:0]        work_b_p1;
  logic [DATA_W-1:0]        acc_p1;
  logic [DATA_W:0]          div_sh_p1;
  logic [DATA_W:0]          div_diff_p1;
  logic [DATA_W-1:0]        mul_add_p1;
  logic [DATA_W-1:0]        md_res_p1;
  logic                     vld_md_p1;

  // Single-cycle ALU; MULT/DIVU/NOP yield zero here.
  function automatic logic [DATA_W-1:0] alu_f(
    input logic [5:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] imm_s,
    input logic [DATA_W-1:0]        imm_z
  );
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:       r = a + b;
      OP_SUB:       r = a - b;
      OP_AND:       r = a & b;
      OP_OR:        r = a | b;
      OP_SLT:       r = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_ADDI:      r = a + imm_s;
      OP_ORI:       r = a | imm_z;
      OP_LW, OP_SW: r = a + imm_s;
      default:      r = '0;
    endcase
    return r;
  endfunction

`ifdef EX_OVF_TRAP_EN
  logic ovf_p0;

  // Signed overflow: operands agree in sign (after negation for SUB) but
  // the wrapped result does not.
  function automatic logic ovf_f(
    input logic [5:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] imm_s,
    input logic [DATA_W-1:0]        res
  );
    logic o;
    case (op)
      OP_ADD:  o = (a[DATA_W-1] == b[DATA_W-1])     && (res[DATA_W-1] != a[DATA_W-1]);
      OP_SUB:  o = (a[DATA_W-1] != b[DATA_W-1])     && (res[DATA_W-1] != a[DATA_W-1]);
      OP_ADDI: o = (a[DATA_W-1] == imm_s[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction
`endif

  // ---- stage p0: decode and single-cycle ALU ----
  assign a_s_p0        = ID_EX_A;
  assign b_s_p0        = ID_EX_B;
  assign imm_sext_p0   = {{(DATA_W-16){ID_EX_imm[15]}}, ID_EX_imm[15:0]};
  assign imm_zext_p0   = {{(DATA_W-16){1'b0}}, ID_EX_imm[15:0]};
  assign unused_imm_hi = ^ID_EX_imm[31:16];

  assign is_rtype_p0 = ID_EX_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MULT, OP_DIVU};
  assign is_itype_p0 = ID_EX_op inside {OP_ADDI, OP_ORI, OP_LW};
  assign writes_p0   = ID_EX_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
                                        OP_ADDI, OP_ORI, OP_MULT, OP_DIVU};
  assign muldiv_p0   = (ID_EX_op == OP_MULT) || (ID_EX_op == OP_DIVU);
  assign dest_p0     = is_rtype_p0 ? ID_EX_rd : (is_itype_p0 ? ID_EX_rt : 5'd0);
  assign alu_res_p0  = alu_f(ID_EX_op, a_s_p0, b_s_p0, imm_sext_p0, imm_zext_p0);

`ifdef EX_OVF_TRAP_EN
  assign ovf_p0 = ovf_f(ID_EX_op, a_s_p0, b_s_p0, imm_sext_p0, alu_res_p0);
  assign vld_p0 = writes_p0 && (dest_p0 != 5'd0) && !ovf_p0;
`else
  assign vld_p0 = writes_p0 && (dest_p0 != 5'd0);
`endif

  // Decode is held while a MULT/DIVU waits to start or iterates; DONE
  // releases it so the next instruction arrives on the result edge.
  assign ex_stall_c = ((state == IDLE) && muldiv_p0) || (state == BUSY);

  // ---- stage p1: iterative multiply / divide ----
  // MULT: acc accumulates work_b (shifted multiplicand) for each set bit of
  // work_a (multiplier, shifted right). DIVU: acc is the partial remainder,
  // work_a shifts the dividend out and the quotient in. A zero divisor
  // never borrows, so the quotient naturally ends as all ones.
  assign div_sh_p1   = {acc_p1, work_a_p1[DATA_W-1]};
  assign div_diff_p1 = div_sh_p1 - {1'b0, work_b_p1};
  assign mul_add_p1  = acc_p1 + (work_a_p1[0] ? work_b_p1 : '0);
  assign md_res_p1   = is_div_p1 ? work_a_p1 : acc_p1;
  assign vld_md_p1   = (ID_EX_rd != 5'd0);

  always_ff @(posedge clock) begin
    if ((state == IDLE) && muldiv_p0 && !mem_stall_c) begin
      is_div_p1 <= (ID_EX_op == OP_DIVU);
      work_a_p1 <= ID_EX_A;
      work_b_p1 <= ID_EX_B;
      acc_p1    <= '0;
    end else if (state == BUSY) begin
      if (is_div_p1) begin
        work_a_p1 <= {work_a_p1[DATA_W-2:0], ~div_diff_p1[DATA_W]};
        acc_p1    <= div_diff_p1[DATA_W] ? div_sh_p1[DATA_W-1:0] : div_diff_p1[DATA_W-1:0];
      end else begin
        acc_p1    <= mul_add_p1;
        work_a_p1 <= work_a_p1 >> 1;
        work_b_p1 <= work_b_p1 << 1;
      end
    end
  end

  // ---- EX/MEM boundary: control FSM and output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      EX_MEM_nextPC <= '0;
      EX_MEM_valid  <= 1'b0;
      EX_MEM_dest   <= '0;
      EX_MEM_result <= '0;
      EX_MEM_B      <= '0;
      EX_MEM_op     <= '0;
`ifdef EX_OVF_TRAP_EN
      ex_ovf        <= 1'b0;
`endif
    end else begin
`ifdef EX_OVF_TRAP_EN
      ex_ovf <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!mem_stall_c) begin
            if (muldiv_p0) begin
              // Start iterating; the slot meanwhile carries a bubble.
              state        <= BUSY;
              count        <= '0;
              EX_MEM_valid <= 1'b0;
            end else begin
              EX_MEM_nextPC <= ID_EX_nextPC;
              EX_MEM_valid  <= vld_p0;
              EX_MEM_dest   <= dest_p0;
              EX_MEM_result <= alu_res_p0;
              EX_MEM_B      <= ID_EX_B;
              EX_MEM_op     <= ID_EX_op;
`ifdef EX_OVF_TRAP_EN
              ex_ovf        <= ovf_p0;
`endif
            end
          end
        end
        BUSY: begin
          if (!mem_stall_c) begin
            EX_MEM_valid <= 1'b0;
          end
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER-1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!mem_stall_c) begin
            EX_MEM_nextPC <= ID_EX_nextPC;
            EX_MEM_valid  <= vld_md_p1;
            EX_MEM_dest   <= ID_EX_rd;
            EX_MEM_result <= md_res_p1;
            EX_MEM_B      <= ID_EX_B;
            EX_MEM_op     <= ID_EX_op;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam int ITER = 32;

  localparam logic [5:0] ADD  = 6'h20, SUB  = 6'h22, AND_ = 6'h24, OR_ = 6'h25;
  localparam logic [5:0] SLT  = 6'h2A, ADDI = 6'h08, ORI  = 6'h0D, LW  = 6'h23;
  localparam logic [5:0] SW   = 6'h2B, MULT = 6'h18, DIVU = 6'h1B, NOP = 6'h00;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        mem_stall_c;
  logic [31:0] ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm;
  logic [4:0]  ID_EX_rd, ID_EX_rt;
  logic [5:0]  ID_EX_op;
  logic [31:0] EX_MEM_nextPC, EX_MEM_result, EX_MEM_B;
  logic        EX_MEM_valid;
  logic [4:0]  EX_MEM_dest;
  logic [5:0]  EX_MEM_op;
  logic        ex_stall_c;
`ifdef EX_OVF_TRAP_EN
  logic        ex_ovf;
`endif

  always #5 clock = ~clock;

  execute_stage #(.DATA_W(32), .ITER(ITER)) dut (
    .clock(clock), .reset_n(reset_n), .mem_stall_c(mem_stall_c),
    .ID_EX_nextPC(ID_EX_nextPC), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rd(ID_EX_rd), .ID_EX_rt(ID_EX_rt),
    .ID_EX_op(ID_EX_op), .EX_MEM_nextPC(EX_MEM_nextPC),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_dest(EX_MEM_dest),
    .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B), .EX_MEM_op(EX_MEM_op),
`ifdef EX_OVF_TRAP_EN
    .ex_ovf(ex_ovf),
`endif
    .ex_stall_c(ex_stall_c)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_muldiv(input logic [5:0] op);
    return (op == MULT) || (op == DIVU);
  endfunction

  function automatic bit m_has_dest(input logic [5:0] op);
    return op inside {ADD, SUB, AND_, OR_, SLT, MULT, DIVU, ADDI, ORI, LW};
  endfunction

  function automatic bit m_writes(input logic [5:0] op);
    return op inside {ADD, SUB, AND_, OR_, SLT, MULT, DIVU, ADDI, ORI};
  endfunction

  function automatic logic [4:0] m_dest(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rt);
    if (op inside {ADD, SUB, AND_, OR_, SLT, MULT, DIVU}) return rd;
    if (op inside {ADDI, ORI, LW}) return rt;
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_result(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] se;
    se = {{16{imm[15]}}, imm[15:0]};
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ADDI:    return a + se;
      ORI:     return a | {16'h0000, imm[15:0]};
      LW, SW:  return a + se;
      MULT:    return a * b;
      DIVU:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

`ifdef EX_OVF_TRAP_EN
  function automatic bit m_ovf(input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm);
    longint sa, sb, si, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    si = longint'($signed(imm[15:0]));
    case (op)
      ADD:     r = sa + sb;
      SUB:     r = sa - sb;
      ADDI:    r = sa + si;
      default: return 1'b0;
    endcase
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction
`endif

  logic [31:0] e_result = '0, e_B = '0, e_pc = '0;
  logic        e_valid = 1'b0, e_ovf = 1'b0;
  logic [4:0]  e_dest = '0;
  logic [5:0]  e_op = '0;
  int          age = 0;
  bit          m_retired = 0;

  task automatic m_load();
    e_result = m_result(ID_EX_op, ID_EX_A, ID_EX_B, ID_EX_imm);
    e_dest   = m_dest(ID_EX_op, ID_EX_rd, ID_EX_rt);
    e_valid  = m_writes(ID_EX_op) && (e_dest != 5'd0);
`ifdef EX_OVF_TRAP_EN
    e_ovf    = m_ovf(ID_EX_op, ID_EX_A, ID_EX_B, ID_EX_imm);
    if (e_ovf) e_valid = 1'b0;
`endif
    e_B  = ID_EX_B;
    e_pc = ID_EX_nextPC;
    e_op = ID_EX_op;
  endtask

  // age = cycles the current instruction has spent in EX. A MULT/DIVU holds
  // decode for its first ITER+1 cycles and retires on the first later edge
  // with MEM free; a single-cycle op retires on the first edge with MEM free.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e_result = '0; e_B = '0; e_pc = '0; e_valid = 1'b0; e_dest = '0;
      e_op = '0; e_ovf = 1'b0; age = 0; m_retired = 0;
    end else begin
      m_retired = 0;
      e_ovf     = 1'b0;
      if (m_muldiv(ID_EX_op) && age <= ITER) begin
        if (!mem_stall_c) e_valid = 1'b0;
        age++;
      end else if (!mem_stall_c) begin
        m_load();
        m_retired = 1;
        age = 0;
      end else begin
        age++;
      end
    end
  end

  // One compare process: every cycle, all outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("result", EX_MEM_result, e_result);
      check("valid",  EX_MEM_valid,  e_valid);
      check("B",      EX_MEM_B,      e_B);
      check("nextPC", EX_MEM_nextPC, e_pc);
      check("op",     EX_MEM_op,     e_op);
      if (m_has_dest(e_op)) check("dest", EX_MEM_dest, e_dest);
      check("stall", ex_stall_c, m_muldiv(ID_EX_op) && (age <= ITER));
`ifdef EX_OVF_TRAP_EN
      check("ovf", ex_ovf, e_ovf);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] pc = 32'h0000_1000;
  int lat, stl;

  // Present one instruction, hold it until the model says it retired.
  // mem_stall_c is raised for stall_len cycles starting at cycle stall_at.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rt,
                       input int stall_at, input int stall_len,
                       output int latency, output int stalls);
    ID_EX_op = op; ID_EX_A = a; ID_EX_B = b; ID_EX_imm = imm;
    ID_EX_rd = rd; ID_EX_rt = rt; ID_EX_nextPC = pc;
    pc += 32'd4;
    latency = 0;
    stalls  = 0;
    forever begin
      if (latency == stall_at) mem_stall_c = 1'b1;
      if (latency == stall_at + stall_len) mem_stall_c = 1'b0;
      #1;
      if (ex_stall_c) stalls++;
      @(posedge clock);
      #1;
      latency++;
      if (m_retired) break;
      if (latency > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout op=0x%02h: no retirement after %0d cycles", op, latency);
        mem_stall_c = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_stall_c = 1'b0;
    ID_EX_nextPC = '0; ID_EX_A = '0; ID_EX_B = '0; ID_EX_imm = '0;
    ID_EX_rd = '0; ID_EX_rt = '0; ID_EX_op = NOP;
    repeat (2) @(posedge clock);
    #1;
    check("rst_result", EX_MEM_result, 32'd0);
    check("rst_stall",  ex_stall_c,    1'b0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    issue(ADD, 32'd5, 32'd7, 32'd0, 5'd3, 5'd0, -1, 0, lat, stl);
    check("add_res", EX_MEM_result, 32'd12);
    check("add_vld", EX_MEM_valid, 1'b1);
    check("add_dest", EX_MEM_dest, 32'd3);
    check("add_lat", lat, 32'd1);
    issue(ADD, 32'd5, 32'd7, 32'd0, 5'd0, 5'd0, -1, 0, lat, stl);
    check("add_rd0_vld", EX_MEM_valid, 1'b0);

    issue(SUB, 32'd3, 32'd10, 32'd0, 5'd6, 5'd0, -1, 0, lat, stl);
    check("sub_res", EX_MEM_result, 32'hFFFF_FFF9);
    issue(AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 5'd7, 5'd0, -1, 0, lat, stl);
    issue(OR_,  32'hF000_0001, 32'h0000_0F00, 32'd0, 5'd8, 5'd0, -1, 0, lat, stl);
    issue(SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 5'd9, 5'd0, -1, 0, lat, stl);
    check("slt_neg", EX_MEM_result, 32'd1);
    issue(SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 5'd9, 5'd0, -1, 0, lat, stl);
    check("slt_pos", EX_MEM_result, 32'd0);
    issue(ADDI, 32'd10, 32'd0, 32'h0000_FFFF, 5'd0, 5'd11, -1, 0, lat, stl);
    check("addi_res", EX_MEM_result, 32'd9);
    issue(ORI,  32'h1000_0000, 32'd0, 32'hFFFF_8001, 5'd0, 5'd12, -1, 0, lat, stl);
    check("ori_res", EX_MEM_result, 32'h1000_8001);
    issue(LW,   32'h0000_2000, 32'd0, 32'h0000_0010, 5'd0, 5'd13, -1, 0, lat, stl);
    check("lw_vld", EX_MEM_valid, 1'b0);
    issue(SW,   32'h0000_0100, 32'h0000_DEAD, 32'h0000_FFFC, 5'd0, 5'd14, -1, 0, lat, stl);
    check("sw_res", EX_MEM_result, 32'h0000_00FC);
    check("sw_B", EX_MEM_B, 32'h0000_DEAD);
    check("sw_op", EX_MEM_op, 32'h2B);
    issue(6'h3F, 32'd1, 32'd2, 32'd0, 5'd5, 5'd5, -1, 0, lat, stl);
    check("bad_op_vld", EX_MEM_valid, 1'b0);

    // MEM stall on entry of a single-cycle op holds the previous result.
    issue(ADD, 32'd1, 32'd1, 32'd0, 5'd2, 5'd0, -1, 0, lat, stl);
    issue(ADD, 32'd40, 32'd2, 32'd0, 5'd4, 5'd0, 0, 2, lat, stl);
    check("add_hold_lat", lat, 32'd3);

    issue(MULT, 32'h0001_0003, 32'h0000_0010, 32'd0, 5'd4, 5'd0, -1, 0, lat, stl);
    check("mult_res", EX_MEM_result, 32'h0010_0030);
    check("mult_stall_cycles", stl, 32'd33);
    check("mult_lat", lat, 32'd34);
    // back-to-back MULT, with a MEM stall while iterating
    issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd5, 5'd0, 5, 3, lat, stl);
    check("mult2_res", EX_MEM_result, 32'd1);
    check("mult2_lat", lat, 32'd34);

    issue(DIVU, 32'd100, 32'd7, 32'd0, 5'd6, 5'd0, -1, 0, lat, stl);
    check("divu_res", EX_MEM_result, 32'd14);
    issue(DIVU, 32'd100, 32'd0, 32'd0, 5'd6, 5'd0, -1, 0, lat, stl);
    check("divu0_res", EX_MEM_result, 32'hFFFF_FFFF);
    check("divu0_lat", lat, 32'd34);
    issue(DIVU, 32'hFFFF_FFFE, 32'd3, 32'd0, 5'd7, 5'd0, 33, 5, lat, stl);
    check("divu_hold_res", EX_MEM_result, 32'h5555_5554);
    check("divu_hold_lat", lat, 32'd39);

    // reset in the middle of a MULT
    ID_EX_op = MULT; ID_EX_A = 32'd9; ID_EX_B = 32'd9; ID_EX_rd = 5'd3;
    repeat (11) @(posedge clock);
    #1;
    reset_n  = 1'b0;
    ID_EX_op = NOP;
    #2;
    check("rst_mid_res", EX_MEM_result, 32'd0);
    check("rst_mid_pc", EX_MEM_nextPC, 32'd0);
    check("rst_mid_stall", ex_stall_c, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    issue(MULT, 32'd1234, 32'd5678, 32'd0, 5'd9, 5'd0, -1, 0, lat, stl);
    check("mult_after_rst", EX_MEM_result, 32'd7006652);
    check("mult_after_rst_lat", lat, 32'd34);

`ifdef EX_OVF_TRAP_EN
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd3, 5'd0, -1, 0, lat, stl);
    check("ovf_add_pulse", ex_ovf, 1'b1);
    check("ovf_add_vld", EX_MEM_valid, 1'b0);
    issue(SUB, 32'h8000_0000, 32'd1, 32'd0, 5'd3, 5'd0, -1, 0, lat, stl);
    check("ovf_sub_pulse", ex_ovf, 1'b1);
    issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, -1, 0, lat, stl);
    check("ovf_clear", ex_ovf, 1'b0);
`endif

    issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, -1, 0, lat, stl);
    @(posedge clock);
    #1;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
